// File: rtl/edge_event_pkg.sv
// Shared helpers for the edge event arbiter: index width derivation and
// one-hot/index conversions sized for the largest supported line count.
package edge_event_pkg;

    localparam int MAX_DW = 32;
    localparam int MAX_IW = 5;

    // Number of bits needed to index n lines (n >= 2).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r++;
        end
        return r;
    endfunction

    // Line index to one-hot vector; callers truncate to their own width.
    function automatic logic [MAX_DW-1:0] idx_to_onehot(input logic [MAX_IW-1:0] idx);
        return MAX_DW'(1) << idx;
    endfunction

    // One-hot vector to line index; zero input yields index 0.
    function automatic logic [MAX_IW-1:0] onehot_to_idx(input logic [MAX_DW-1:0] oh);
        logic [MAX_IW-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_DW; i++) begin
            if (oh[i]) begin
                r = r | MAX_IW'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/edge2pulse.sv
// Library cell: per-bit toggle detector. Output is high for one cycle
// whenever the input differs from its value at the previous clock edge.
module edge2pulse #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic [DW-1:0] in,
    output logic [DW-1:0] out
);

    logic [DW-1:0] in_reg;

    // Remember last cycle's level; cleared so a line high at reset release pulses once.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            in_reg <= '0;
        end else begin
            in_reg <= in;
        end
    end

    assign out = in ^ in_reg;

endmodule

// File: rtl/edge_event_arbiter_rr_pick.sv
// Combinational round-robin picker. The request vector is duplicated so the
// search from ptr upward wraps naturally; bits below ptr in the lower copy
// are masked off and the lowest remaining bit wins.
module rr_pick
    import edge_event_pkg::*;
#(
    parameter int  DW = 8,
    localparam int IW = clog2(DW)
) (
    input  logic [DW-1:0] req,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_id
);

    localparam int W2 = 2 * DW;

    logic [W2-1:0] req2;
    logic [W2-1:0] mask2;
    logic [W2-1:0] masked;
    logic [W2-1:0] first;
    logic [DW-1:0] gnt_oh;

    // Masked double-width priority encode, folded back to a single one-hot grant.
    always_comb begin
        req2      = {req, req};
        mask2     = {W2{1'b1}} << ptr;
        masked    = req2 & mask2;
        first     = masked & (~masked + W2'(1));
        gnt_oh    = first[DW-1:0] | first[W2-1:DW];
        gnt_valid = |req;
        gnt_id    = IW'(onehot_to_idx(MAX_DW'(gnt_oh)));
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Edge event arbiter: toggles on level inputs become pending flags, which a
// round-robin picker hands out one at a time through a registered
// valid/ready slot. Repeated toggles on a still-pending line are recorded
// as sticky overrun flags.
module edge_event_arbiter
    import edge_event_pkg::*;
#(
    parameter int  DW = 8,
    localparam int IW = clog2(DW)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] in,
    input  logic [DW-1:0] en,
    output logic          evt_valid,
    output logic [IW-1:0] evt_id,
    input  logic          evt_ready,
    output logic [DW-1:0] pending,
    output logic [DW-1:0] ovf,
    input  logic [DW-1:0] ovf_clr
);

    logic          nreset;
    logic [DW-1:0] pulse;
    logic          accept;
    logic          load;
    logic [DW-1:0] presented_oh;
    logic [DW-1:0] accepted_oh;
    logic [DW-1:0] new_evt;
    logic [DW-1:0] pending_next;
    logic [DW-1:0] ovf_set;
    logic [DW-1:0] ovf_next;
    logic [DW-1:0] pick_req;
    logic [IW-1:0] ptr;
    logic [IW-1:0] id_plus1;
    logic [IW-1:0] search_ptr;
    logic          gnt_valid;
    logic [IW-1:0] gnt_id;

    assign nreset = ~reset;

    edge2pulse #(
        .DW(DW)
    ) u_edge (
        .clk   (clk),
        .nreset(nreset),
        .in    (in),
        .out   (pulse)
    );

    // Next-state terms for pending/ovf and the request set seen by the picker.
    always_comb begin
        accept       = evt_valid & evt_ready;
        load         = ~evt_valid | accept;
        presented_oh = evt_valid ? DW'(idx_to_onehot(MAX_IW'(evt_id))) : '0;
        accepted_oh  = accept ? presented_oh : '0;
        new_evt      = pulse & en;
        // A disabled line loses its flag unless it is the one being presented,
        // so the presented id always keeps pending set until accepted.
        pending_next = (pending & ~accepted_oh & (en | presented_oh)) | new_evt;
        // The line being accepted may be re-armed by a fresh pulse without overrun.
        ovf_set      = new_evt & pending & ~accepted_oh;
        ovf_next     = (ovf & ~ovf_clr) | ovf_set;
        id_plus1     = (evt_id == IW'(DW - 1)) ? '0 : evt_id + IW'(1);
        // Searching from just past the accepted id keeps back-to-back service fair.
        search_ptr   = accept ? id_plus1 : ptr;
        // Lines whose enable is dropping this cycle are not handed out, so a
        // cleared flag can never be presented. Same-cycle pulses are excluded
        // because only registered pending feeds the picker.
        pick_req     = pending & ~accepted_oh & en;
    end

    rr_pick #(
        .DW(DW)
    ) u_pick (
        .req      (pick_req),
        .ptr      (search_ptr),
        .gnt_valid(gnt_valid),
        .gnt_id   (gnt_id)
    );

    // Pending and sticky overrun flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            ovf     <= '0;
        end else begin
            pending <= pending_next;
            ovf     <= ovf_next;
        end
    end

    // Round-robin pointer advances past each accepted id.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= id_plus1;
        end
    end

    // Output slot: refilled from the picker whenever empty or just accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_valid <= 1'b0;
            evt_id    <= '0;
        end else if (load) begin
            evt_valid <= gnt_valid;
            if (gnt_valid) begin
                evt_id <= gnt_id;
            end
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed scenarios with hand-computed
// expectations, then randomized traffic against a behavioural model.
module tb_edge_event_arbiter;

    localparam int DW = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_s;
    logic [DW-1:0] en_s;
    logic [DW-1:0] ovf_clr;
    logic          evt_ready;
    logic          evt_valid;
    logic [IW-1:0] evt_id;
    logic [DW-1:0] pending;
    logic [DW-1:0] ovf;

    always #5 clk = ~clk;

    edge_event_arbiter #(
        .DW(DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in_s),
        .en       (en_s),
        .evt_valid(evt_valid),
        .evt_id   (evt_id),
        .evt_ready(evt_ready),
        .pending  (pending),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Behavioural model state
    bit [DW-1:0] m_prev;
    bit [DW-1:0] m_pend;
    bit [DW-1:0] m_ovf;
    bit          m_sv;
    int          m_sid;
    int          m_ptr;

    // Acceptance log observed on the DUT ports
    int acc_log[$];
    int acc_cyc[$];
    bit last_acc;
    int last_id;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_prev = '0;
        m_pend = '0;
        m_ovf  = '0;
        m_sv   = 1'b0;
        m_sid  = 0;
        m_ptr  = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit [DW-1:0] np;
        bit [DW-1:0] no;
        bit          acc;
        bit          found;
        int          start;
        int          idx;
        int          new_ptr;
        bit          new_sv;
        int          new_sid;
        acc = m_sv && evt_ready;
        np  = '0;
        no  = '0;
        for (int i = 0; i < DW; i++) begin
            bit pulse_i;
            bit newe;
            bit is_pres;
            bit is_acc;
            pulse_i = (in_s[i] != m_prev[i]);
            newe    = pulse_i && en_s[i];
            is_pres = m_sv && (m_sid == i);
            is_acc  = acc && (m_sid == i);
            np[i]   = (m_pend[i] && !is_acc && (en_s[i] || is_pres)) || newe;
            no[i]   = (m_ovf[i] && !ovf_clr[i]) || (newe && m_pend[i] && !is_acc);
        end
        new_ptr = acc ? (m_sid + 1) % DW : m_ptr;
        new_sv  = m_sv;
        new_sid = m_sid;
        if (!m_sv || acc) begin
            start = new_ptr;
            found = 1'b0;
            idx   = 0;
            for (int k = 0; k < DW; k++) begin
                int c;
                c = (start + k) % DW;
                if (!found && m_pend[c] && en_s[c] && !(acc && c == m_sid)) begin
                    found = 1'b1;
                    idx   = c;
                end
            end
            new_sv = found;
            if (found) new_sid = idx;
        end
        m_pend = np;
        m_ovf  = no;
        m_ptr  = new_ptr;
        m_sv   = new_sv;
        m_sid  = new_sid;
        m_prev = in_s;
    endtask

    // One clock: log DUT acceptance, step model, then compare all outputs.
    task automatic step();
        last_acc = evt_valid && evt_ready;
        last_id  = int'(evt_id);
        if (last_acc) begin
            acc_log.push_back(last_id);
            acc_cyc.push_back(cyc);
        end
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        chk("evt_valid", 32'(evt_valid), 32'(m_sv));
        if (m_sv) chk("evt_id", 32'(evt_id), 32'(m_sid));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    initial begin
        int bad;
        reset     = 1'b1;
        in_s      = '0;
        en_s      = '0;
        ovf_clr   = '0;
        evt_ready = 1'b0;
        last_acc  = 1'b0;
        last_id   = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst evt_valid", 32'(evt_valid), 32'h0);
        chk("rst evt_id", 32'(evt_id), 32'h0);
        chk("rst pending", 32'(pending), 32'h0);
        chk("rst ovf", 32'(ovf), 32'h0);

        // Line 0 high at reset release
        @(negedge clk);
        in_s      = 8'h01;
        en_s      = 8'hFF;
        evt_ready = 1'b1;
        reset     = 1'b0;
        step();
        chk("t1 pending after 1", 32'(pending), 32'h01);
        chk("t1 valid after 1", 32'(evt_valid), 32'h0);
        step();
        chk("t1 valid after 2", 32'(evt_valid), 32'h1);
        chk("t1 id after 2", 32'(evt_id), 32'h0);
        step();
        chk("t1 pending drained", 32'(pending), 32'h0);
        chk("t1 accepted count", 32'(acc_log.size()), 32'd1);
        chk("t1 accepted id", 32'(acc_log.size() > 0 ? acc_log[0] : -1), 32'd0);

        // Lines 1, 3, 6 together, ready held
        acc_log.delete();
        acc_cyc.delete();
        in_s ^= 8'h4A;
        repeat (6) step();
        chk("t2 accept count", 32'(acc_log.size()), 32'd3);
        if (acc_log.size() == 3) begin
            chk("t2 id0", 32'(acc_log[0]), 32'd1);
            chk("t2 id1", 32'(acc_log[1]), 32'd3);
            chk("t2 id2", 32'(acc_log[2]), 32'd6);
            chk("t2 back-to-back", 32'(acc_cyc[2] - acc_cyc[0]), 32'd2);
        end
        chk("t2 model ptr", 32'(m_ptr), 32'd7);

        // Hold ready low while line 2 toggles three times
        acc_log.delete();
        evt_ready = 1'b0;
        repeat (3) begin
            in_s ^= 8'h04;
            step();
        end
        repeat (3) step();
        chk("t3 ovf set", 32'(ovf), 32'h04);
        chk("t3 held valid", 32'(evt_valid), 32'h1);
        chk("t3 held id", 32'(evt_id), 32'd2);
        evt_ready = 1'b1;
        repeat (2) step();
        chk("t3 single accept", 32'(acc_log.size()), 32'd1);
        chk("t3 accepted id", 32'(acc_log.size() > 0 ? acc_log[0] : -1), 32'd2);
        chk("t3 pending clear", 32'(pending), 32'h0);
        chk("t3 ovf sticky", 32'(ovf), 32'h04);
        ovf_clr = 8'h04;
        step();
        ovf_clr = 8'h00;
        chk("t3 ovf cleared", 32'(ovf), 32'h0);

        // Fairness: lines 0 and 5 re-toggled after each acceptance
        acc_log.delete();
        in_s ^= 8'h21;
        step();
        repeat (14) begin
            if (last_acc) in_s[last_id] = ~in_s[last_id];
            step();
        end
        repeat (4) step();
        chk("t4 enough accepts", 32'(acc_log.size() >= 6), 32'h1);
        chk("t4 first id", 32'(acc_log.size() > 0 ? acc_log[0] : -1), 32'd5);
        bad = 0;
        for (int i = 0; i < acc_log.size(); i++) begin
            if (acc_log[i] != 0 && acc_log[i] != 5) bad++;
            if (i > 0 && acc_log[i] == acc_log[i-1]) bad++;
        end
        chk("t4 alternation", 32'(bad), 32'd0);

        // Masked line 4, then enable dropped while pending but not presented
        acc_log.delete();
        en_s = 8'hEF;
        in_s ^= 8'h10;
        repeat (3) step();
        chk("t5 masked pending", 32'(pending), 32'h0);
        chk("t5 masked valid", 32'(evt_valid), 32'h0);
        en_s      = 8'hFF;
        evt_ready = 1'b0;
        in_s ^= 8'h02;
        repeat (2) step();
        in_s ^= 8'h10;
        step();
        chk("t5 both pending", 32'(pending), 32'h12);
        chk("t5 presented id", 32'(evt_id), 32'd1);
        en_s = 8'hEF;
        step();
        chk("t5 line4 dropped", 32'(pending), 32'h02);
        evt_ready = 1'b1;
        repeat (3) step();
        chk("t5 accept count", 32'(acc_log.size()), 32'd1);
        chk("t5 accepted id", 32'(acc_log.size() > 0 ? acc_log[0] : -1), 32'd1);
        en_s = 8'hFF;
        step();

        // Reset in the middle of a handshake
        evt_ready = 1'b0;
        in_s ^= 8'h30;
        repeat (2) step();
        chk("t6 pre pending", 32'(pending), 32'h30);
        chk("t6 pre valid", 32'(evt_valid), 32'h1);
        reset = 1'b1;
        #1;
        chk("t6 async valid", 32'(evt_valid), 32'h0);
        chk("t6 async id", 32'(evt_id), 32'h0);
        chk("t6 async pending", 32'(pending), 32'h0);
        chk("t6 async ovf", 32'(ovf), 32'h0);
        model_reset();
        in_s = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset     = 1'b0;
        evt_ready = 1'b1;
        repeat (4) step();
        chk("t6 quiet valid", 32'(evt_valid), 32'h0);
        chk("t6 quiet pending", 32'(pending), 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            in_s ^= 8'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) en_s = 8'($urandom | $urandom);
            else if ($urandom_range(0, 7) == 0) en_s = 8'hFF;
            ovf_clr   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            evt_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
